// File: rtl/wave_channel_scheduler_pkg.sv
// Shared definitions for the wave channel scheduler.
//   - default parameter values (N_FRAC, NUM_CH, TIMEOUT)
//   - data-word width helper
//   - 3-bit FSM state encoding
package wave_channel_scheduler_pkg;

    localparam int DEF_N_FRAC  = 7;
    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_TIMEOUT = 32;

    // All data words are signed N_FRAC+1 bits wide.
    function automatic int data_w(input int n_frac);
        return n_frac + 1;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_STORE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/wave_ch_regfile.sv
// Per-channel register file: enable, phase increment, amplitude, phase
// accumulator and output sample for each of NUM_CH channels.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   cfg_*_i             config write port (en/inc/amp written together, clr zeroes phase)
//   ch_i                channel in flight: selects read data, phase advance and sample write
//   adv_i               phase[ch_i] += inc[ch_i] (mod 2^W)
//   smp_we_i, smp_d_i   sample[ch_i] <= smp_d_i
//   en_o                all channel enables
//   rd_amp_o/rd_phase_o amplitude and phase of ch_i
//   sample_o            all samples, channel 0 in element 0
module wave_ch_regfile #(
    parameter  int NUM_CH = 4,
    parameter  int W      = 8,
    localparam int CW     = $clog2(NUM_CH)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_we_i,
    input  logic [CW-1:0]                cfg_ch_i,
    input  logic                         cfg_en_i,
    input  logic                         cfg_clr_i,
    input  logic [W-1:0]                 cfg_inc_i,
    input  logic [W-1:0]                 cfg_amp_i,
    input  logic [CW-1:0]                ch_i,
    input  logic                         adv_i,
    input  logic                         smp_we_i,
    input  logic [W-1:0]                 smp_d_i,
    output logic [NUM_CH-1:0]            en_o,
    output logic [W-1:0]                 rd_amp_o,
    output logic [W-1:0]                 rd_phase_o,
    output logic [NUM_CH-1:0][W-1:0]     sample_o
);

    logic [NUM_CH-1:0][W-1:0] amp_vec, phase_vec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic         en_q;
        logic [W-1:0] inc_q, amp_q, phase_q, sample_q;
        logic         sel_cfg, sel_cur;

        assign sel_cfg = cfg_we_i && (cfg_ch_i == CW'(i));
        assign sel_cur = (ch_i == CW'(i));

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                en_q     <= 1'b0;
                inc_q    <= '0;
                amp_q    <= '0;
                phase_q  <= '0;
                sample_q <= '0;
            end else begin
                if (sel_cfg) begin
                    en_q  <= cfg_en_i;
                    inc_q <= cfg_inc_i;
                    amp_q <= cfg_amp_i;
                end
                // A clear beats an advance landing in the same cycle.
                if (sel_cfg && cfg_clr_i)
                    phase_q <= '0;
                else if (adv_i && sel_cur)
                    phase_q <= phase_q + inc_q;
                if (smp_we_i && sel_cur)
                    sample_q <= smp_d_i;
            end
        end

        assign en_o[i]      = en_q;
        assign amp_vec[i]   = amp_q;
        assign phase_vec[i] = phase_q;
        assign sample_o[i]  = sample_q;
    end

    assign rd_amp_o   = amp_vec[ch_i];
    assign rd_phase_o = phase_vec[ch_i];

endmodule

// File: rtl/wave_channel_scheduler.sv
// Time-multiplexes one shared CORDIC across NUM_CH wave channels. Each sample
// tick walks the enabled channels in ascending order: issue a request with the
// channel's phase/amplitude, wait for the result, store it as that channel's
// sample. Disabled channels read 0.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   sample_tick_i                start a frame (dropped and flagged if busy)
//   cfg_we_i/ch/en/clr/inc/amp   channel config write
//   cordic_x_o/z_o/strobe_o      request to the CORDIC (x/z held until STORE)
//   cordic_x_i/valid_i           CORDIC result
//   sample_o                     per-channel samples, ch0 in the LSBs
//   frame_done_o                 1-cycle strobe at end of frame
//   busy_o                       not IDLE
//   overrun_o, timeout_o         sticky error flags
module wave_channel_scheduler
    import wave_channel_scheduler_pkg::*;
#(
    parameter  int N_FRAC  = DEF_N_FRAC,
    parameter  int NUM_CH  = DEF_NUM_CH,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int W       = data_w(N_FRAC),
    localparam int CW      = $clog2(NUM_CH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sample_tick_i,
    input  logic                  cfg_we_i,
    input  logic [CW-1:0]         cfg_ch_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_clr_i,
    input  logic [W-1:0]          cfg_inc_i,
    input  logic [W-1:0]          cfg_amp_i,
    output logic [W-1:0]          cordic_x_o,
    output logic [W-1:0]          cordic_z_o,
    output logic                  cordic_strobe_o,
    input  logic [W-1:0]          cordic_x_i,
    input  logic                  cordic_valid_i,
    output logic [NUM_CH*W-1:0]   sample_o,
    output logic                  frame_done_o,
    output logic                  busy_o,
    output logic                  overrun_o,
    output logic                  timeout_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [W-1:0]    req_x_q, req_x_d, req_z_q, req_z_d;
    logic            ovr_q, ovr_d, tmo_q, tmo_d;

    logic                     adv, smp_we, strobe, last_ch;
    logic [W-1:0]             smp_d, rd_amp, rd_phase;
    logic [NUM_CH-1:0]        en_vec;
    logic [NUM_CH-1:0][W-1:0] smp_arr;

    wave_ch_regfile #(.NUM_CH(NUM_CH), .W(W)) u_regs (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cfg_we_i   (cfg_we_i),
        .cfg_ch_i   (cfg_ch_i),
        .cfg_en_i   (cfg_en_i),
        .cfg_clr_i  (cfg_clr_i),
        .cfg_inc_i  (cfg_inc_i),
        .cfg_amp_i  (cfg_amp_i),
        .ch_i       (ch_q),
        .adv_i      (adv),
        .smp_we_i   (smp_we),
        .smp_d_i    (smp_d),
        .en_o       (en_vec),
        .rd_amp_o   (rd_amp),
        .rd_phase_o (rd_phase),
        .sample_o   (smp_arr)
    );

    assign last_ch = (ch_q == CW'(NUM_CH - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            tcnt_q  <= '0;
            req_x_q <= '0;
            req_z_q <= '0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            tcnt_q  <= tcnt_d;
            req_x_q <= req_x_d;
            req_z_q <= req_z_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        tcnt_d  = tcnt_q;
        req_x_d = req_x_q;
        req_z_d = req_z_q;
        ovr_d   = ovr_q | (sample_tick_i && (state_q != ST_IDLE));
        tmo_d   = tmo_q;
        adv     = 1'b0;
        smp_we  = 1'b0;
        smp_d   = cordic_x_i;
        strobe  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sample_tick_i) begin
                    state_d = ST_SCAN;
                    ch_d    = '0;
                end
            end
            ST_SCAN: begin
                if (en_vec[ch_q]) begin
                    // Latch the request here so config writes during the
                    // request cannot disturb what the CORDIC sees.
                    state_d = ST_ISSUE;
                    req_x_d = rd_amp;
                    req_z_d = rd_phase;
                end else begin
                    smp_we = 1'b1;
                    smp_d  = '0;
                    if (last_ch) state_d = ST_DONE;
                    else         ch_d    = ch_q + 1'b1;
                end
            end
            ST_ISSUE: begin
                strobe  = 1'b1;
                adv     = 1'b1;
                tcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cordic_valid_i) begin
                    state_d = ST_STORE;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    // Abandon the request; the old sample is kept.
                    tmo_d = 1'b1;
                    if (last_ch) state_d = ST_DONE;
                    else begin
                        state_d = ST_SCAN;
                        ch_d    = ch_q + 1'b1;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_STORE: begin
                smp_we = 1'b1;
                if (last_ch) state_d = ST_DONE;
                else begin
                    state_d = ST_SCAN;
                    ch_d    = ch_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign cordic_x_o      = req_x_q;
    assign cordic_z_o      = req_z_q;
    assign cordic_strobe_o = strobe;
    assign sample_o        = smp_arr;
    assign frame_done_o    = (state_q == ST_DONE);
    assign busy_o          = (state_q != ST_IDLE);
    assign overrun_o       = ovr_q;
    assign timeout_o       = tmo_q;

endmodule

// File: tb/tb_wave_channel_scheduler.sv
// Bench for wave_channel_scheduler: behavioural CORDIC with fixed latency and a
// per-channel frame model computed from the scheduling rules.
module tb_wave_channel_scheduler;

    localparam int NCH = 4;
    localparam int TMO = 32;
    localparam int L   = 8;

    logic       clk_i = 1'b0, rst_i = 1'b0, sample_tick_i = 1'b0;
    logic       cfg_we_i = 1'b0, cfg_en_i = 1'b0, cfg_clr_i = 1'b0;
    logic [1:0] cfg_ch_i = '0;
    logic [7:0] cfg_inc_i = '0, cfg_amp_i = '0;
    logic [7:0] cordic_x_o, cordic_z_o;
    logic       cordic_strobe_o;
    logic [7:0] cordic_x_i = '0;
    logic       cordic_valid_i = 1'b0;
    logic [31:0] sample_o;
    logic       frame_done_o, busy_o, overrun_o, timeout_o;

    int errors = 0, checks = 0;

    wave_channel_scheduler #(.N_FRAC(7), .NUM_CH(NCH), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sample_tick_i(sample_tick_i),
        .cfg_we_i(cfg_we_i), .cfg_ch_i(cfg_ch_i), .cfg_en_i(cfg_en_i), .cfg_clr_i(cfg_clr_i),
        .cfg_inc_i(cfg_inc_i), .cfg_amp_i(cfg_amp_i),
        .cordic_x_o(cordic_x_o), .cordic_z_o(cordic_z_o), .cordic_strobe_o(cordic_strobe_o),
        .cordic_x_i(cordic_x_i), .cordic_valid_i(cordic_valid_i),
        .sample_o(sample_o), .frame_done_o(frame_done_o), .busy_o(busy_o),
        .overrun_o(overrun_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural CORDIC: result is an arbitrary but deterministic function of x/z.
    function automatic logic [7:0] cres(input logic [7:0] x, input logic [7:0] z);
        return x ^ {z[3:0], z[7:4]} ^ 8'h5A;
    endfunction

    int ncnt = 0, st_cnt = 0, drop_idx = -1, drop_n = -1, tmo_n = -1;
    int dl_q[$];
    logic [7:0] rv_q[$], obs_z[$], obs_x[$];

    always @(negedge clk_i) begin : responder
        int hit;
        ncnt++;
        hit = -1;
        cordic_valid_i = 1'b0;
        if (!rst_i) begin
            dl_q.delete();
            rv_q.delete();
        end
        for (int i = 0; i < dl_q.size(); i++)
            if (hit < 0 && dl_q[i] == ncnt) hit = i;
        if (hit >= 0) begin
            cordic_valid_i = 1'b1;
            cordic_x_i     = rv_q[hit];
            dl_q.delete(hit);
            rv_q.delete(hit);
        end
        if (cordic_strobe_o) begin
            obs_z.push_back(cordic_z_o);
            obs_x.push_back(cordic_x_o);
            if (st_cnt == drop_idx) begin
                // Result arrives long after the scheduler gave up on it.
                drop_n = ncnt;
                dl_q.push_back(ncnt + 50);
                rv_q.push_back(~cres(cordic_x_o, cordic_z_o));
            end else begin
                dl_q.push_back(ncnt + L);
                rv_q.push_back(cres(cordic_x_o, cordic_z_o));
            end
            st_cnt++;
        end
        if (timeout_o && tmo_n < 0) tmo_n = ncnt;
    end

    // ---------------- reference model ----------------
    bit         m_en[NCH];
    logic [7:0] m_inc[NCH], m_amp[NCH], m_ph[NCH], m_smp[NCH];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_en[c] = 0; m_inc[c] = '0; m_amp[c] = '0; m_ph[c] = '0; m_smp[c] = '0;
        end
    endtask

    function automatic logic [31:0] m_pack();
        logic [31:0] v;
        for (int c = 0; c < NCH; c++) v[c*8 +: 8] = m_smp[c];
        return v;
    endfunction

    task automatic cfg(input int ch, input bit en, input bit clr, input logic [7:0] inc, input logic [7:0] amp);
        @(negedge clk_i);
        cfg_we_i = 1'b1; cfg_ch_i = 2'(ch); cfg_en_i = en; cfg_clr_i = clr;
        cfg_inc_i = inc; cfg_amp_i = amp;
        @(negedge clk_i);
        cfg_we_i = 1'b0; cfg_clr_i = 1'b0;
        m_en[ch] = en; m_inc[ch] = inc; m_amp[ch] = amp;
        if (clr) m_ph[ch] = '0;
    endtask

    // Mid-frame actions (offsets counted in cycles after the tick cycle).
    int mw_at = -1, mw_ch = 0, mt_at = -1, drop_ch = -1;
    bit mw_en, mw_clr, mt_done = 0;
    logic [7:0] mw_inc, mw_amp;

    // Frame results: length, and up to four strobes packed {z,x} with the first in the LSBs.
    int f_len, f_exp, f_gn, f_en;
    logic [63:0] f_gs, f_es;

    task automatic run_frame();
        int pos, s0;
        f_exp = 0; pos = 0; f_es = '0; f_gs = '0; drop_idx = -1;
        for (int c = 0; c < NCH; c++) begin
            if (m_en[c]) begin
                f_es[pos*16 +: 16] = {m_ph[c], m_amp[c]};
                if (c == drop_ch) begin
                    drop_idx = st_cnt + pos;
                    f_exp += 2 + TMO;
                end else begin
                    m_smp[c] = cres(m_amp[c], m_ph[c]);
                    f_exp += 3 + L;
                end
                m_ph[c] = m_ph[c] + m_inc[c];
                pos++;
            end else begin
                m_smp[c] = '0;
                f_exp += 1;
            end
        end
        f_en = pos;
        s0 = obs_z.size();
        f_len = -1;
        @(negedge clk_i);
        sample_tick_i = 1'b1;
        for (int i = 1; i <= 2000 && f_len < 0; i++) begin
            @(negedge clk_i);
            sample_tick_i = 1'b0; cfg_we_i = 1'b0; cfg_clr_i = 1'b0;
            if (i == mw_at) begin
                cfg_we_i = 1'b1; cfg_ch_i = 2'(mw_ch); cfg_en_i = mw_en; cfg_clr_i = mw_clr;
                cfg_inc_i = mw_inc; cfg_amp_i = mw_amp;
            end
            if (frame_done_o) f_len = i;
            if (i == mt_at || (mt_done && frame_done_o)) sample_tick_i = 1'b1;
        end
        @(negedge clk_i);
        sample_tick_i = 1'b0; cfg_we_i = 1'b0; cfg_clr_i = 1'b0;
        #1;
        f_gn = obs_z.size() - s0;
        for (int k = 0; k < f_gn && k < 4; k++) f_gs[k*16 +: 16] = {obs_z[s0+k], obs_x[s0+k]};
        if (mw_at > 0) begin
            m_en[mw_ch] = mw_en; m_inc[mw_ch] = mw_inc; m_amp[mw_ch] = mw_amp;
            if (mw_clr) m_ph[mw_ch] = '0;
        end
        mw_at = -1; mt_at = -1; mt_done = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        #1;
        checks++; if (sample_o !== 32'h0) begin errors++; $display("FAIL reset_sample: got %h want 0", sample_o); end
        checks++; if ({busy_o, frame_done_o, cordic_strobe_o, overrun_o, timeout_o} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {busy_o, frame_done_o, cordic_strobe_o, overrun_o, timeout_o}); end
        checks++; if ({cordic_x_o, cordic_z_o} !== 16'h0) begin errors++; $display("FAIL reset_req: got %h want 0", {cordic_x_o, cordic_z_o}); end
        model_reset();
        @(negedge clk_i); rst_i = 1'b1;
    endtask

    task automatic test_single();
        cfg(0, 1, 0, 8'h10, 8'h40);
        for (int k = 0; k < 3; k++) begin
            run_frame();
            checks++; if (f_len !== 15) begin errors++; $display("FAIL single_len%0d: got %0d want 15", k, f_len); end
            checks++; if ({f_gn, f_gs} !== {32'sd1, 48'h0, 8'(8'h10 * k), 8'h40}) begin
                errors++; $display("FAIL single_req%0d: got n=%0d %h want n=1 z=%h x=40", k, f_gn, f_gs, 8'(8'h10 * k)); end
            checks++; if (sample_o !== m_pack()) begin errors++; $display("FAIL single_smp%0d: got %h want %h", k, sample_o, m_pack()); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] zexp [3];
        zexp = '{8'h00, 8'h70, 8'hE0};
        cfg(0, 1, 1, 8'h70, 8'h40);
        for (int k = 0; k < 3; k++) begin
            run_frame();
            checks++; if (f_gs[15:8] !== zexp[k]) begin errors++; $display("FAIL wrap_z%0d: got %h want %h", k, f_gs[15:8], zexp[k]); end
            checks++; if (sample_o !== m_pack() || sample_o[31:8] !== 24'h0) begin
                errors++; $display("FAIL wrap_smp%0d: got %h want %h", k, sample_o, m_pack()); end
        end
    endtask

    task automatic test_overrun();
        int d;
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_pre: got %b want 0", overrun_o); end
        mt_at = 5;
        run_frame();
        checks++; if (f_len !== f_exp + 1) begin errors++; $display("FAIL ovr_len: got %0d want %0d", f_len, f_exp + 1); end
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun_o); end
        d = 0;
        repeat (30) begin @(negedge clk_i); if (frame_done_o) d++; end
        checks++; if (d !== 0) begin errors++; $display("FAIL ovr_extra_done: got %0d want 0", d); end
        run_frame();
        checks++; if ({f_gn, f_gs} !== {f_en, f_es}) begin errors++; $display("FAIL ovr_next_req: got %h want %h", f_gs, f_es); end
    endtask

    task automatic test_reset_mid();
        cfg(0, 1, 1, 8'h10, 8'h40);
        @(negedge clk_i); sample_tick_i = 1'b1;
        repeat (5) begin @(negedge clk_i); sample_tick_i = 1'b0; end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b want 1", busy_o); end
        #2 rst_i = 1'b0;
        #1;
        checks++; if (sample_o !== 32'h0) begin errors++; $display("FAIL rstmid_sample: got %h want 0", sample_o); end
        checks++; if ({busy_o, overrun_o, timeout_o, cordic_x_o, cordic_z_o} !== 19'h0) begin
            errors++; $display("FAIL rstmid_outs: got %h want 0", {busy_o, overrun_o, timeout_o, cordic_x_o, cordic_z_o}); end
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        cfg(0, 1, 0, 8'h10, 8'h40);
        run_frame();
        checks++; if ({f_gn, f_gs} !== {32'sd1, 48'h0, 16'h0040}) begin errors++; $display("FAIL rstmid_req: got %h want 0040", f_gs); end
        checks++; if (f_len !== 15 || sample_o !== m_pack()) begin
            errors++; $display("FAIL rstmid_frame: got len=%0d smp=%h want 15 %h", f_len, sample_o, m_pack()); end
    endtask

    task automatic test_done_overrun();
        int d;
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL dovr_pre: got %b want 0", overrun_o); end
        mt_done = 1;
        run_frame();
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL dovr_flag: got %b want 1", overrun_o); end
        d = 0;
        repeat (30) begin @(negedge clk_i); if (frame_done_o || busy_o) d++; end
        checks++; if (d !== 0) begin errors++; $display("FAIL dovr_extra: got %0d busy/done cycles want 0", d); end
    endtask

    task automatic test_collision();
        cfg(0, 1, 1, 8'h10, 8'h40);
        run_frame();
        // amp and clr written while ch0 is waiting on its result
        mw_at = 5; mw_ch = 0; mw_en = 1; mw_clr = 1; mw_inc = 8'h10; mw_amp = 8'h20;
        run_frame();
        checks++; if (f_gs[15:0] !== 16'h1040) begin errors++; $display("FAIL coll_cur_req: got %h want 1040", f_gs[15:0]); end
        checks++; if (sample_o !== m_pack()) begin errors++; $display("FAIL coll_cur_smp: got %h want %h", sample_o, m_pack()); end
        run_frame();
        checks++; if (f_gs[15:0] !== 16'h0020) begin errors++; $display("FAIL coll_next_req: got %h want 0020", f_gs[15:0]); end
        // clr in the very cycle of the ISSUE increment
        mw_at = 2; mw_ch = 0; mw_en = 1; mw_clr = 1; mw_inc = 8'h10; mw_amp = 8'h20;
        run_frame();
        run_frame();
        checks++; if (f_gs[15:0] !== 16'h0020) begin errors++; $display("FAIL coll_issue_clr: got %h want 0020", f_gs[15:0]); end
        // disable the channel in flight: result still stored
        mw_at = 5; mw_ch = 0; mw_en = 0; mw_clr = 0; mw_inc = 8'h10; mw_amp = 8'h20;
        run_frame();
        checks++; if (sample_o !== m_pack() || sample_o[7:0] === 8'h0) begin
            errors++; $display("FAIL coll_dis_store: got %h want %h", sample_o, m_pack()); end
        run_frame();
        checks++; if ({f_gn, sample_o} !== {32'sd0, 32'h0}) begin errors++; $display("FAIL coll_dis_next: got n=%0d %h want 0 0", f_gn, sample_o); end
    endtask

    task automatic test_timeout();
        logic [31:0] keep;
        cfg(0, 1, 1, 8'h11, 8'h21);
        cfg(1, 1, 1, 8'h22, 8'h32);
        cfg(2, 1, 1, 8'h30, 8'h43);
        cfg(3, 1, 1, 8'h44, 8'h54);
        run_frame();
        checks++; if ({f_gn, f_gs, sample_o} !== {f_en, f_es, m_pack()}) begin
            errors++; $display("FAIL tmo_pre: got %h %h want %h %h", f_gs, sample_o, f_es, m_pack()); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL tmo_pre_flag: got %b want 0", timeout_o); end
        drop_ch = 2;
        run_frame();
        drop_ch = -1;
        checks++; if (f_len !== f_exp + 1) begin errors++; $display("FAIL tmo_len: got %0d want %0d", f_len, f_exp + 1); end
        checks++; if ({f_gn, f_gs} !== {f_en, f_es}) begin errors++; $display("FAIL tmo_req: got n=%0d %h want n=%0d %h", f_gn, f_gs, f_en, f_es); end
        checks++; if (sample_o !== m_pack()) begin errors++; $display("FAIL tmo_smp: got %h want %h", sample_o, m_pack()); end
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b want 1", timeout_o); end
        // flag registered at the end of the TMO-th WAIT cycle after the ISSUE cycle
        checks++; if (tmo_n - drop_n !== TMO + 1) begin errors++; $display("FAIL tmo_time: got %0d want %0d", tmo_n - drop_n, TMO + 1); end
        keep = m_pack();
        repeat (12) @(negedge clk_i);
        checks++; if ({busy_o, sample_o} !== {1'b0, keep}) begin errors++; $display("FAIL tmo_late: got %b %h want 0 %h", busy_o, sample_o, keep); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < NCH; c++)
                cfg(c, ($urandom % 4) != 0, ($urandom % 5) == 0, 8'($urandom), 8'($urandom));
            run_frame();
            checks++; if (f_len !== f_exp + 1) begin errors++; $display("FAIL rnd_len%0d: got %0d want %0d", k, f_len, f_exp + 1); end
            checks++; if ({f_gn, f_gs} !== {f_en, f_es}) begin errors++; $display("FAIL rnd_req%0d: got n=%0d %h want n=%0d %h", k, f_gn, f_gs, f_en, f_es); end
            checks++; if (sample_o !== m_pack()) begin errors++; $display("FAIL rnd_smp%0d: got %h want %h", k, sample_o, m_pack()); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_overrun();
        test_reset_mid();
        test_done_overrun();
        test_collision();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
